scan_sequencer: RTL and testbench

Sequential channel-scan controller that drives the enable and 2-bit select inputs of the 2-to-4 decoder in the combinational library. On a start request it steps the select through channels 0..3, holding each for a programmable dwell time, in single-pass or continuous mode. It reports progress with `busy` and a one-cycle `done` pulse. Its `en` and `a` outputs connect directly to the decoder's `en` and `a` ports.

---
 rtl/scan_sequencer.sv | 130 +++++++++++++
 tb/tb_scan_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Channel-scan controller for the 2-to-4 decoder; optional channel mask under SCAN_SEQ_MASK_EN.
// Registered outputs, one cycle from start to first channel; no backpressure, stop aborts at once.
module scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic               en,
  output logic [1:0]         a,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           mask_q, mask_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           a_q, a_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;
  logic [3:0]           mask_in;
  logic [2:0]           nxt;

`ifdef SCAN_SEQ_MASK_EN
  assign mask_in = mask;
`else
  logic unused_mask;
  assign unused_mask = ^mask;
  assign mask_in     = 4'hF;
`endif

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_ch = 2'(i);
    end
  endfunction

  // {found, channel}: lowest enabled channel strictly above cur.
  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    next_ch = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_ch = {1'b1, 2'(i)};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    en_d    = en_q;
    done_d  = 1'b0;
    nxt     = next_ch(mask_q, a_q);
    case (state_q)
      IDLE: begin
        if (start && !stop && (|mask_in)) begin
          state_d = SCAN;
          mode_d  = mode;
          dwell_d = dwell;
          mask_d  = mask_in;
          cnt_d   = '0;
          a_d     = lowest_ch(mask_in);
          en_d    = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          a_d     = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (nxt[2]) begin
            a_d = nxt[1:0];
          end else if (mode_q) begin
            a_d = lowest_ch(mask_q);
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
            a_d     = 2'd0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      mask_q  <= 4'd0;
      cnt_q   <= '0;
      a_q     <= 2'd0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign en   = en_q;
  assign a    = a_q;
  assign busy = (state_q == SCAN);
  assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized bench for scan_sequencer against a schedule-queue reference model.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [3:0] dwell, mask;
  logic       en, busy, done;
  logic [1:0] a;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the remaining channel schedule of the current pass.
  int         sched[$];
  bit         scanning = 0;
  bit         cont = 0;
  logic [3:0] pass_mask = 4'd0;
  int         pass_dwell = 0;
  logic       exp_en, exp_busy, exp_done;
  logic [1:0] exp_a;

  scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .dwell(dwell), .mask(mask), .en(en), .a(a), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] eff_mask(input logic [3:0] m);
`ifdef SCAN_SEQ_MASK_EN
    return m;
`else
    return 4'hF;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_pass();
    for (int ch = 0; ch < 4; ch++)
      if (pass_mask[ch])
        for (int k = 0; k <= pass_dwell; k++) sched.push_back(ch);
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic m,
                      input logic [3:0] dw, input logic [3:0] mk);
    rst = r; start = s; stop = p; mode = m; dwell = dw; mask = mk;
    @(posedge clk);
    exp_en = 1'b0; exp_a = 2'd0; exp_busy = 1'b0; exp_done = 1'b0;
    if (r) begin
      sched.delete();
      scanning = 0;
    end else if (scanning) begin
      if (p) begin
        sched.delete();
        scanning = 0;
      end else begin
        if (sched.size() == 0 && cont) build_pass();
        if (sched.size() != 0) begin
          exp_a = 2'(sched.pop_front());
          exp_en = 1'b1;
          exp_busy = 1'b1;
        end else begin
          scanning = 0;
          exp_done = 1'b1;
        end
      end
    end else if (s && !p && eff_mask(mk) != 4'd0) begin
      pass_mask  = eff_mask(mk);
      pass_dwell = int'(dw);
      cont       = m;
      scanning   = 1;
      sched.delete();
      build_pass();
      exp_a = 2'(sched.pop_front());
      exp_en = 1'b1;
      exp_busy = 1'b1;
    end
    #1;
    check("en", 32'(en), 32'(exp_en));
    check("a", 32'(a), 32'(exp_a));
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    // Reset held with start asserted.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF);
    idle_cycles(2);

    // Single pass, dwell 0, all channels.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF);
    idle_cycles(6);

    // Continuous, dwell 2, mask 1010, with ignored start/config changes.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'b1010);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle_cycles(2);

    // Stop at cycle 3 of a dwell-3 pass.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'hF);
    idle_cycles(2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    idle_cycles(3);

    // Zero-mask start, start with stop in IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
    idle_cycles(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'hF);
    idle_cycles(2);

    // Reset mid-scan, then a fresh start.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    idle_cycles(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'b0110);
    idle_cycles(12);

    // Back-to-back passes with start held high.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b1001);
    idle_cycles(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       r, s, p, m;
      logic [3:0] dw, mk;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 39) == 0);
      m  = 1'($urandom_range(0, 1));
      dw = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      mk = 4'($urandom_range(0, 15));
      step(r, s, p, m, dw, mk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
